// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit geometry, coordinate width and output-port codes.
package noc_pkg;

  localparam int unsigned FLIT_W  = 8;
  localparam int unsigned COORD_W = 2;
  localparam int unsigned DIR_W   = 3;

  localparam int unsigned X_DEST_MSB = 7;
  localparam int unsigned X_DEST_LSB = 6;
  localparam int unsigned Y_DEST_MSB = 5;
  localparam int unsigned Y_DEST_LSB = 4;

  localparam logic [DIR_W-1:0] LOCAL = 3'd0;
  localparam logic [DIR_W-1:0] EAST  = 3'd1;
  localparam logic [DIR_W-1:0] WEST  = 3'd2;
  localparam logic [DIR_W-1:0] NORTH = 3'd3;
  localparam logic [DIR_W-1:0] SOUTH = 3'd4;
  localparam logic [DIR_W-1:0] IDLE  = 3'd7;

endpackage

// File: rtl/xy_route.sv
// Dimension-ordered (X then Y) route decision for a single flit.
module xy_route
  import noc_pkg::*;
(
  input  logic [COORD_W-1:0] X_cur,
  input  logic [COORD_W-1:0] Y_cur,
  input  logic [FLIT_W-1:0]  flit,
  input  logic               empty,
  output logic [DIR_W-1:0]   register
);

  logic [COORD_W-1:0] x_dest;
  logic [COORD_W-1:0] y_dest;

  assign x_dest = flit[X_DEST_MSB:X_DEST_LSB];
  assign y_dest = flit[Y_DEST_MSB:Y_DEST_LSB];

  always_comb begin
    register = IDLE;
    if (!empty) begin
      if (x_dest > X_cur) begin
        register = EAST;
      end else if (x_dest < X_cur) begin
        register = WEST;
      end else if (y_dest > Y_cur) begin
        register = NORTH;
      end else if (y_dest < Y_cur) begin
        register = SOUTH;
      end else begin
        register = LOCAL;
      end
    end
  end

endmodule

// File: rtl/block_input.sv
// Router input port: flit FIFO with combinational head presentation and XY route request.
module block_input
  import noc_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = FLIT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COORD_W-1:0] X_cur,
  input  logic [COORD_W-1:0] Y_cur,
  input  logic               val,
  input  logic [W-1:0]       Data_in,
  output logic               ret,
  output logic [W-1:0]       Data_out,
  output logic [DIR_W-1:0]   register,
  input  logic               s_ack
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full, empty, push, pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign ret   = ~full & ~rst;
  assign push  = val & ret;
  assign pop   = s_ack & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is left unreset; empty gating keeps stale entries invisible.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= Data_in;
    end
  end

  assign Data_out = empty ? '0 : mem[rd_ptr_q];

  xy_route u_xy_route (
    .X_cur    (X_cur),
    .Y_cur    (Y_cur),
    .flit     (Data_out),
    .empty    (empty),
    .register (register)
  );

endmodule

// File: tb/tb_block_input.sv
// Self-checking bench for block_input: queue-based reference model plus directed literal checks.
module tb_block_input;

  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] X_cur, Y_cur;
  logic       val, s_ack;
  logic [7:0] Data_in;
  logic       ret;
  logic [7:0] Data_out;
  logic [2:0] register;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] model_q[$];

  block_input #(.DEPTH(DEPTH), .W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .X_cur    (X_cur),
    .Y_cur    (Y_cur),
    .val      (val),
    .Data_in  (Data_in),
    .ret      (ret),
    .Data_out (Data_out),
    .register (register),
    .s_ack    (s_ack)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] route(input logic [7:0] f, input logic [1:0] xc,
                                       input logic [1:0] yc);
    int xd, yd;
    xd = int'(f) / 64;
    yd = (int'(f) / 16) % 4;
    if (xd > int'(xc)) return 3'd1;
    if (xd < int'(xc)) return 3'd2;
    if (yd > int'(yc)) return 3'd3;
    if (yd < int'(yc)) return 3'd4;
    return 3'd0;
  endfunction

  // Reference model: queue semantics straight from the push/pop/reset rules.
  always @(posedge clk) begin
    if (rst) begin
      model_q.delete();
    end else begin
      automatic bit do_pop  = s_ack && (model_q.size() > 0);
      automatic bit do_push = val && (model_q.size() < DEPTH);
      if (do_pop) void'(model_q.pop_front());
      if (do_push) model_q.push_back(Data_in);
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst !== 1'bx) begin
      automatic logic       e_ret  = (model_q.size() < DEPTH) && !rst;
      automatic logic [7:0] e_data = (model_q.size() > 0) ? model_q[0] : 8'h00;
      automatic logic [2:0] e_reg  = (model_q.size() > 0) ? route(model_q[0], X_cur, Y_cur)
                                                          : 3'd7;
      check("model_ret", {7'd0, ret}, {7'd0, e_ret});
      check("model_data", Data_out, e_data);
      check("model_reg", {5'd0, register}, {5'd0, e_reg});
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push1(input logic [7:0] f);
    Data_in = f;
    val = 1'b1;
    step();
    val = 1'b0;
  endtask

  logic [7:0] fill [4] = '{8'hAF, 8'hFA, 8'hF8, 8'hF0};
  logic [7:0] rt_flit [5] = '{8'h50, 8'h10, 8'h60, 8'h40, 8'hD0};
  logic [2:0] rt_exp [5] = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd1};

  initial begin
    rst = 1'b1; val = 1'b0; s_ack = 1'b0; Data_in = 8'h00; X_cur = 2'd0; Y_cur = 2'd0;
    step(); step();
    rst = 1'b0;
    step();
    check("reset_ret", {7'd0, ret}, 8'd1);
    check("reset_data", Data_out, 8'h00);
    check("reset_reg", {5'd0, register}, 8'd7);

    // Single flit east and back out
    push1(8'b1010_1111);
    check("single_data", Data_out, 8'hAF);
    check("single_reg", {5'd0, register}, 8'd1);
    s_ack = 1'b1; step(); s_ack = 1'b0;
    check("single_pop_reg", {5'd0, register}, 8'd7);
    check("single_pop_data", Data_out, 8'h00);

    // Fill to full, reject a fifth flit, drain in order
    val = 1'b1;
    foreach (fill[i]) begin
      Data_in = fill[i];
      step();
    end
    check("full_ret", {7'd0, ret}, 8'd0);
    Data_in = 8'hB0;
    step();
    check("full_reject_ret", {7'd0, ret}, 8'd0);
    check("full_head", Data_out, 8'hAF);
    val = 1'b0;
    s_ack = 1'b1;
    for (int i = 1; i < 4; i++) begin
      step();
      check("drain_data", Data_out, fill[i]);
      check("drain_ret", {7'd0, ret}, 8'd1);
    end
    step();
    s_ack = 1'b0;
    check("drain_empty", Data_out, 8'h00);

    // Route table from (1,1)
    X_cur = 2'd1; Y_cur = 2'd1;
    foreach (rt_flit[i]) begin
      push1(rt_flit[i]);
      check("route_tbl", {5'd0, register}, {5'd0, rt_exp[i]});
      s_ack = 1'b1; step(); s_ack = 1'b0;
    end

    // Coordinate change re-evaluates route immediately
    X_cur = 2'd3; Y_cur = 2'd0;
    push1(8'hC0);
    check("coord_local", {5'd0, register}, 8'd0);
    X_cur = 2'd0;
    #1;
    check("coord_east", {5'd0, register}, 8'd1);
    s_ack = 1'b1; step(); s_ack = 1'b0;

    // Simultaneous push and pop with two stored
    push1(8'h11);
    push1(8'h22);
    Data_in = 8'h33; val = 1'b1; s_ack = 1'b1;
    step();
    val = 1'b0; s_ack = 1'b0;
    check("sim_head", Data_out, 8'h22);
    check("sim_ret", {7'd0, ret}, 8'd1);
    s_ack = 1'b1;
    step();
    check("sim_tail", Data_out, 8'h33);
    step();
    check("sim_empty", Data_out, 8'h00);
    s_ack = 1'b0;

    // Reset mid-operation overrides concurrent push
    push1(8'hA1); push1(8'hA2); push1(8'hA3);
    rst = 1'b1; val = 1'b1; Data_in = 8'hA4; s_ack = 1'b1;
    step();
    val = 1'b0; s_ack = 1'b0;
    check("rst_reg", {5'd0, register}, 8'd7);
    check("rst_data", Data_out, 8'h00);
    check("rst_ret_held", {7'd0, ret}, 8'd0);
    rst = 1'b0;
    #1;
    check("rst_ret_rel", {7'd0, ret}, 8'd1);
    s_ack = 1'b1; step(); s_ack = 1'b0;
    check("empty_ack_data", Data_out, 8'h00);
    check("empty_ack_reg", {5'd0, register}, 8'd7);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/block_input.md
BLOCK_INPUT -- requirements
Module: block_input

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk and rst.
REQ-002 Port list SHALL be as follows.
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- X_cur  input  2  X coordinate of this router
- Y_cur  input  2  Y coordinate of this router
- val  input  1  upstream flit valid
- Data_in  input  8  upstream flit
- ret  output  1  ready/accept back to upstream
- Data_out  output  8  head flit toward switch
- register  output  3  output-port request for the head flit
- s_ack  input  1  switch accepted Data_out this cycle

REQ-003 Parameters SHALL be:
- DEPTH, default 4, FIFO entries (power of 2)
- W, default 8, flit width

Function
REQ-004 Flit format SHALL be:
- [7:6] X_dest
- [5:4] Y_dest
- [3:0] payload
- every flit is a single-flit packet, routed independently.

REQ-005 ret SHALL equal (not full) AND (not rst), combinationally.

REQ-006 Push SHALL occur on a rising clk when val=1 and ret=1; Data_in is written at the tail.

REQ-007 When val=1 and the FIFO is full, Data_in SHALL be ignored; upstream must hold it.

REQ-008 Data_out SHALL present the head entry combinationally, and SHALL be 8'h00 when empty.

REQ-009 register SHALL be the XY route of the head flit, computed combinationally, X first:
- X_dest>X_cur -> 3'd1 EAST
- X_dest<X_cur -> 3'd2 WEST
- else Y_dest>Y_cur -> 3'd3 NORTH
- Y_dest<Y_cur -> 3'd4 SOUTH
- else -> 3'd0 LOCAL
- empty FIFO -> 3'd7 IDLE

REQ-010 Pop SHALL occur on a rising clk when s_ack=1 and the FIFO is not empty; s_ack while empty SHALL be ignored.

REQ-011 Simultaneous push and pop SHALL both take effect and leave the count unchanged.
- Because ret=0 when full, no push occurs in a full cycle.
- A pop in a full cycle raises ret the next cycle.

REQ-012 Ordering SHALL be strict FIFO. Read and write pointers wrap modulo DEPTH. Count width SHALL be log2(DEPTH)+1.

REQ-013 Latency: a flit pushed at edge N SHALL appear on Data_out/register after edge N if the FIFO was empty (one cycle).

REQ-014 X_cur/Y_cur changes SHALL immediately re-evaluate register; they are quasi-static in use.

Reset
REQ-015 On rst=1 at a rising clk, the block SHALL set:
- pointers and count to 0
- Data_out=8'h00
- register=3'd7
- ret=1 after rst deasserts

REQ-016 rst SHALL override any simultaneous push or pop. Stored flits SHALL be discarded on reset mid-operation.

REQ-017 FIFO storage contents SHALL need no reset.

Structure
REQ-018 A shared package noc_pkg SHALL hold:
- FLIT_W=8
- coordinate width 2
- direction constants LOCAL=0, EAST=1, WEST=2, NORTH=3, SOUTH=4, IDLE=7
- flit field bit positions

REQ-019 The route computation SHALL be a combinational sub-module xy_route with inputs X_cur, Y_cur, the flit and an empty flag, and output register. The FIFO SHALL stay inline.

Verification
REQ-020 After reset with X_cur=Y_cur=0: ret=1, Data_out=8'h00, register=3'd7.

REQ-021 Single flit, X_cur=Y_cur=0, Data_in=8'b10101111, val=1 for one cycle:
- next cycle Data_out=8'hAF, register=3'd1 (EAST)
- s_ack=1 for one cycle -> FIFO empty, register=3'd7

REQ-022 Fill the FIFO with val=1 and s_ack=0 using 8'hAF, 8'hFA, 8'hF8, 8'hF0:
- ret=0 after the 4th push
- a 5th flit 8'hB0 is not accepted
- then s_ack=1 -> Data_out sequence AF, FA, F8, F0 in order; ret returns to 1 after the first pop.

REQ-023 Route table with X_cur=1, Y_cur=1:
- flit 8'h50 -> LOCAL (0)
- 8'h10 -> WEST (2)
- 8'h60 -> NORTH (3)
- 8'h40 -> SOUTH (4)
- 8'hD0 -> EAST (1)

REQ-024 Simultaneous val=1 and s_ack=1 with 2 entries stored: count stays 2, head advances, new flit goes to the tail.

REQ-025 rst=1 asserted with 3 entries stored: next cycle register=3'd7, Data_out=8'h00, ret=1 once rst=0; s_ack while empty produces no change.
